// File: rtl/ram_request_arbiter.sv
// Shares one SDRAM request port among NUM_REQ requesters: fixed priority for
// requester 0 (bounded by a hog limiter), round-robin for the rest, ack watchdog.
module ram_request_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned HOG_LIMIT  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                            CLK,
  input  logic                            RESET_n,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ-1:0]              WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   WDATA,
  output logic [NUM_REQ-1:0]              ACK,
  output logic [DATA_WIDTH-1:0]           RDATA,
  output logic                            ERR,
  output logic                            MEM_REQ,
  output logic                            MEM_WE,
  output logic [ADDR_WIDTH-1:0]           MEM_ADDR,
  output logic [DATA_WIDTH-1:0]           MEM_WDATA,
  input  logic                            MEM_ACK,
  input  logic [DATA_WIDTH-1:0]           MEM_RDATA,
  output logic [$clog2(NUM_REQ)-1:0]      GRANT_ID,
  output logic                            BUSY
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned HCW = $clog2(HOG_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [HCW-1:0]          hog_q, hog_d;
  logic [7:0]              wd_q, wd_d;

  logic [NUM_REQ-1:0]      elig;
  logic                    others_elig;
  logic                    pick0;
  logic                    rr_found;
  logic [IDW-1:0]          rr_idx;
  logic                    pick_valid;
  logic [IDW-1:0]          pick_id;

  // The requester being acked this cycle still holds REQ; mask it out.
  assign elig        = REQ & ~ack_q;
  assign others_elig = |elig[NUM_REQ-1:1];
  assign pick0       = elig[0] && ((hog_q < HCW'(HOG_LIMIT)) || !others_elig);

  always_comb begin
    logic [IDW-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = rr_q;
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
      cand = (cand == IDW'(NUM_REQ - 1)) ? IDW'(1) : cand + IDW'(1);
    end
  end

  assign pick_valid = pick0 || rr_found;
  assign pick_id    = pick0 ? '0 : rr_idx;

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    hog_d       = hog_q;
    wd_d        = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          mem_we_d    = WE[pick_id];
          mem_addr_d  = ADDR[pick_id * ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = WDATA[pick_id * DATA_WIDTH +: DATA_WIDTH];
          grant_d     = pick_id;
          state_d     = S_ISSUE;
          if (pick0) begin
            if (!others_elig) begin
              hog_d = '0;
            end else if (hog_q != HCW'(HOG_LIMIT)) begin
              hog_d = hog_q + HCW'(1);
            end
          end else begin
            hog_d = '0;
            rr_d  = (pick_id == IDW'(NUM_REQ - 1)) ? IDW'(1) : pick_id + IDW'(1);
          end
        end
      end

      S_ISSUE: begin
        mem_req_d = 1'b1;
        wd_d      = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // An ack on the final watchdog cycle still wins over the timeout.
        if (MEM_ACK) begin
          rdata_d = MEM_RDATA;
          ack_d   = NUM_REQ'(1) << grant_q;
          state_d = S_IDLE;
        end else if (wd_q == 8'(TIMEOUT)) begin
          rdata_d = '1;
          ack_d   = NUM_REQ'(1) << grant_q;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      grant_q     <= '0;
      rr_q        <= IDW'(1);
      hog_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      hog_q       <= hog_d;
      wd_q        <= wd_d;
    end
  end

  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign RDATA     = rdata_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign GRANT_ID  = grant_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed testbench for ram_request_arbiter; the bench plays the requesters
// and the SDRAM controller, driving and sampling on the falling clock edge.
module tb_ram_request_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;

  logic            CLK = 1'b0;
  logic            RESET_n;
  logic [NR-1:0]   REQ, WE, ACK;
  logic [NR*AW-1:0] ADDR;
  logic [NR*DW-1:0] WDATA;
  logic [DW-1:0]   RDATA, MEM_WDATA, MEM_RDATA;
  logic            ERR, MEM_REQ, MEM_WE, MEM_ACK, BUSY;
  logic [AW-1:0]   MEM_ADDR;
  logic [1:0]      GRANT_ID;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_request_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOG_LIMIT(4), .TIMEOUT(255)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .GRANT_ID(GRANT_ID), .BUSY(BUSY)
  );

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    RESET_n = 1'b0;
    step(); step();
    RESET_n = 1'b1;
  endtask

  // Returns the number of cycles until MEM_REQ is seen (40 means never).
  task automatic wait_memreq(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!MEM_REQ && cyc < 40);
  endtask

  task automatic mem_ack(input int delay, input logic [DW-1:0] d);
    repeat (delay) step();
    MEM_ACK = 1'b1; MEM_RDATA = d;
    step();
    MEM_ACK = 1'b0; MEM_RDATA = 16'h0BAD;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ACK, ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA, GRANT_ID} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b err=%b mreq=%b mwe=%b maddr=%h mwd=%h rd=%h gid=%0d exp all zero",
               ACK, ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, RDATA, GRANT_ID);
    end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
  endtask

  task automatic test_single_read();
    int cyc;
    do_reset();
    ADDR[1*AW +: AW] = 23'h012345; REQ = 3'b010;
    wait_memreq(cyc);
    total++;
    if (cyc !== 2) begin bad++; $display("FAIL read_latency got=%0d exp=2", cyc); end
    total++;
    if (MEM_ADDR !== 23'h012345) begin bad++; $display("FAIL read_addr got=%h exp=012345", MEM_ADDR); end
    total++;
    if (MEM_WE !== 1'b0) begin bad++; $display("FAIL read_we got=%b exp=0", MEM_WE); end
    total++;
    if (GRANT_ID !== 2'd1 || BUSY !== 1'b1) begin
      bad++; $display("FAIL read_grant got gid=%0d busy=%b exp gid=1 busy=1", GRANT_ID, BUSY);
    end
    step();
    total++;
    if (MEM_REQ !== 1'b0) begin bad++; $display("FAIL read_memreq_pulse got=%b exp=0", MEM_REQ); end
    mem_ack(4, 16'hBEEF);
    total++;
    if (ACK !== 3'b010 || RDATA !== 16'hBEEF || ERR !== 1'b0) begin
      bad++; $display("FAIL read_ack got ack=%b rd=%h err=%b exp ack=010 rd=beef err=0", ACK, RDATA, ERR);
    end
    REQ = '0;
    step();
    total++;
    if (ACK !== 3'b000 || RDATA !== 16'hBEEF || BUSY !== 1'b0) begin
      bad++; $display("FAIL read_after got ack=%b rd=%h busy=%b exp ack=000 rd=beef busy=0", ACK, RDATA, BUSY);
    end
  endtask

  task automatic test_write();
    int cyc;
    do_reset();
    ADDR[2*AW +: AW] = 23'h7FFFFF; WDATA[2*DW +: DW] = 16'h55AA; WE = 3'b100; REQ = 3'b100;
    wait_memreq(cyc);
    total++;
    if (MEM_WE !== 1'b1 || MEM_ADDR !== 23'h7FFFFF || MEM_WDATA !== 16'h55AA) begin
      bad++; $display("FAIL write_cmd got we=%b addr=%h wd=%h exp we=1 addr=7fffff wd=55aa", MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    total++;
    if (GRANT_ID !== 2'd2) begin bad++; $display("FAIL write_grant got=%0d exp=2", GRANT_ID); end
    mem_ack(1, 16'h1234);
    total++;
    if (ACK !== 3'b100 || ERR !== 1'b0) begin
      bad++; $display("FAIL write_ack got ack=%b err=%b exp ack=100 err=0", ACK, ERR);
    end
    total++;
    if (MEM_ADDR !== 23'h7FFFFF || MEM_WE !== 1'b1) begin
      bad++; $display("FAIL write_hold got addr=%h we=%b exp addr=7fffff we=1", MEM_ADDR, MEM_WE);
    end
    REQ = '0; WE = '0;
    step();
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp_g[4] = '{1, 2, 1, 2};
    do_reset();
    ADDR[1*AW +: AW] = 23'h000111; ADDR[2*AW +: AW] = 23'h000222; REQ = 3'b110;
    for (int i = 0; i < 4; i++) begin
      wait_memreq(cyc);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL rr_latency[%0d] got=%0d exp=2", i, cyc); end
      total++;
      if (GRANT_ID !== 2'(exp_g[i])) begin bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, GRANT_ID, exp_g[i]); end
      total++;
      if (MEM_ADDR !== (exp_g[i] == 1 ? 23'h000111 : 23'h000222)) begin
        bad++; $display("FAIL rr_addr[%0d] got=%h exp_req=%0d", i, MEM_ADDR, exp_g[i]);
      end
      mem_ack(2, 16'(i));
      total++;
      if (ACK !== (3'b001 << exp_g[i])) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp_req=%0d", i, ACK, exp_g[i]); end
    end
    REQ = '0;
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp_g[6] = '{0, 1, 0, 2, 0, 1};
    do_reset();
    REQ = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_memreq(cyc);
      total++;
      if (cyc !== 2) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=2", i, cyc); end
      total++;
      if (GRANT_ID !== 2'(exp_g[i])) begin bad++; $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", i, GRANT_ID, exp_g[i]); end
      mem_ack(0, 16'hA000 + 16'(i));
      total++;
      if (ACK !== (3'b001 << exp_g[i]) || RDATA !== 16'hA000 + 16'(i)) begin
        bad++; $display("FAIL b2b_ack[%0d] got ack=%b rd=%h exp_req=%0d", i, ACK, RDATA, exp_g[i]);
      end
    end
    REQ = '0;
    step();
  endtask

  task automatic test_hog_limit();
    int cyc;
    int exp_g[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0};
    do_reset();
    for (int r = 0; r < 11; r++) begin
      REQ = 3'b111;
      step();
      total++;
      if (GRANT_ID !== 2'(exp_g[r]) || BUSY !== 1'b1) begin
        bad++; $display("FAIL hog_grant[%0d] got gid=%0d busy=%b exp gid=%0d busy=1", r, GRANT_ID, BUSY, exp_g[r]);
      end
      REQ = '0;
      wait_memreq(cyc);
      mem_ack(1, 16'h5000 + 16'(r));
      total++;
      if (ACK !== (3'b001 << exp_g[r])) begin bad++; $display("FAIL hog_ack[%0d] got=%b exp_req=%0d", r, ACK, exp_g[r]); end
      step();
    end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    ADDR[1*AW +: AW] = 23'h00ABCD; REQ = 3'b010;
    wait_memreq(cyc);
    repeat (255) step();
    total++;
    if (ACK !== 3'b000 || ERR !== 1'b0) begin
      bad++; $display("FAIL timeout_early got ack=%b err=%b exp ack=000 err=0", ACK, ERR);
    end
    step();
    total++;
    if (ACK !== 3'b010 || ERR !== 1'b1 || RDATA !== 16'hFFFF) begin
      bad++; $display("FAIL timeout_ack got ack=%b err=%b rd=%h exp ack=010 err=1 rd=ffff", ACK, ERR, RDATA);
    end
    REQ = '0;
    step();
    total++;
    if (ACK !== 3'b000 || ERR !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse got ack=%b err=%b exp ack=000 err=0", ACK, ERR);
    end
    ADDR[2*AW +: AW] = 23'h000042; REQ = 3'b100;
    wait_memreq(cyc);
    total++;
    if (cyc !== 2 || MEM_ADDR !== 23'h000042) begin
      bad++; $display("FAIL timeout_next_req got cyc=%0d addr=%h exp cyc=2 addr=000042", cyc, MEM_ADDR);
    end
    mem_ack(3, 16'hCAFE);
    total++;
    if (ACK !== 3'b100 || ERR !== 1'b0 || RDATA !== 16'hCAFE) begin
      bad++; $display("FAIL timeout_next_ack got ack=%b err=%b rd=%h exp ack=100 err=0 rd=cafe", ACK, ERR, RDATA);
    end
    REQ = '0;
    step();
  endtask

  task automatic test_ack_at_limit();
    int cyc;
    do_reset();
    REQ = 3'b001;
    wait_memreq(cyc);
    mem_ack(255, 16'h0F0F);
    total++;
    if (ACK !== 3'b001 || ERR !== 1'b0 || RDATA !== 16'h0F0F) begin
      bad++; $display("FAIL limit_ack got ack=%b err=%b rd=%h exp ack=001 err=0 rd=0f0f", ACK, ERR, RDATA);
    end
    REQ = '0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    do_reset();
    ADDR[0 +: AW] = 23'h000ABC; WDATA[0 +: DW] = 16'h1111; WE = 3'b001; REQ = 3'b001;
    wait_memreq(cyc);
    step(); step();
    RESET_n = 1'b0; REQ = '0; WE = '0;
    step();
    RESET_n = 1'b1;
    total++;
    if ({BUSY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, GRANT_ID} !== '0) begin
      bad++; $display("FAIL midreset_state got busy=%b mreq=%b mwe=%b maddr=%h mwd=%h gid=%0d exp all zero",
                      BUSY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, GRANT_ID);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    step();
    MEM_ACK = 1'b0;
    total++;
    if (ACK !== 3'b000 || ERR !== 1'b0 || RDATA !== 16'h0000 || BUSY !== 1'b0) begin
      bad++; $display("FAIL midreset_late_ack got ack=%b err=%b rd=%h busy=%b exp ack=000 err=0 rd=0000 busy=0",
                      ACK, ERR, RDATA, BUSY);
    end
    REQ = 3'b001;
    wait_memreq(cyc);
    total++;
    if (cyc !== 2 || GRANT_ID !== 2'd0 || MEM_WE !== 1'b0) begin
      bad++; $display("FAIL midreset_regrant got cyc=%0d gid=%0d we=%b exp cyc=2 gid=0 we=0", cyc, GRANT_ID, MEM_WE);
    end
    mem_ack(1, 16'h2222);
    total++;
    if (ACK !== 3'b001 || RDATA !== 16'h2222) begin
      bad++; $display("FAIL midreset_ack got ack=%b rd=%h exp ack=001 rd=2222", ACK, RDATA);
    end
    REQ = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_hog_limit();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_request_arbiter.md
Name: ram_request_arbiter

Overview:
- Shares one SDRAM request port among NUM_REQ requesters: CPU RAM, V9990 VRAM fetch, and the DMA/loader path.
- Sits between the requesters and the SDRAM controller's request side, in the CLK (108 MHz) domain.
- Requester 0 has priority. The remaining requesters are served round-robin.
- A hog limiter keeps requester 0 from starving the others, and a watchdog ensures a lost memory acknowledge cannot hang the bus.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 23, word address width.
- DATA_WIDTH, 16, data width.
- HOG_LIMIT, 4, maximum consecutive requester-0 grants while any other request is pending.
- TIMEOUT, 255, maximum CLK cycles to wait for MEM_ACK (8-bit counter).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_n  in  1  synchronous active-low reset.
- REQ  in  NUM_REQ  per-requester request level; held until the matching ACK.
- WE  in  NUM_REQ  per-requester write flag; 1 = write.
- ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH].
- WDATA  in  NUM_REQ*DATA_WIDTH  packed write data, same packing scheme.
- ACK  out  NUM_REQ  one-cycle completion pulse per requester.
- RDATA  out  DATA_WIDTH  read data; valid in the ACK cycle and held until the next ACK.
- ERR  out  1  one-cycle pulse, coincident with ACK, when the access timed out.
- MEM_REQ  out  1  one-cycle command strobe to the SDRAM controller.
- MEM_WE  out  1  write flag to the controller.
- MEM_ADDR  out  ADDR_WIDTH  address to the controller.
- MEM_WDATA  out  DATA_WIDTH  write data to the controller.
- MEM_ACK  in  1  one-cycle completion pulse from the controller.
- MEM_RDATA  in  DATA_WIDTH  read data from the controller, valid with MEM_ACK.
- GRANT_ID  out  $clog2(NUM_REQ)  index of the current or last grant.
- BUSY  out  1  high in the ISSUE and WAIT states.

Behaviour:
- Reset (RESET_n low at a clock edge):
  - state IDLE, ACK=0, ERR=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, RDATA=0.
  - GRANT_ID=0, BUSY=0, rr_ptr=1, hog_cnt=0, wd_cnt=0.
  - Reset mid-transaction aborts it with no ACK. A late MEM_ACK arriving after reset, while in IDLE, is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - Eligible set = REQ & ~ACK. This masks the requester being acked in the current cycle.
  - Selection:
    - If REQ[0] is eligible and (hog_cnt < HOG_LIMIT or no other requester is eligible), pick 0.
    - Otherwise pick the first eligible index >= rr_ptr among 1..NUM_REQ-1, wrapping from NUM_REQ-1 to 1.
  - On a pick:
    - Latch WE/ADDR/WDATA of the winner into MEM_WE/MEM_ADDR/MEM_WDATA.
    - Set GRANT_ID to the winner and go to ISSUE.
  - With no eligible requester, stay in IDLE.
- hog_cnt and rr_ptr update on each grant:
  - Grant to 0 with other requesters eligible: hog_cnt+1, saturating at HOG_LIMIT.
  - Grant to 0 with no other requester eligible: hog_cnt cleared.
  - Grant to i>0: hog_cnt cleared and rr_ptr = i+1, wrapping NUM_REQ -> 1.
- ISSUE: MEM_REQ=1 for exactly this one cycle; wd_cnt cleared; go to WAIT.
- WAIT:
  - MEM_ACK=1: RDATA<=MEM_RDATA (writes also capture it; the value is don't-care), ACK[GRANT_ID] pulses next cycle, go to IDLE.
  - wd_cnt==TIMEOUT without MEM_ACK: RDATA<=all ones, ACK[GRANT_ID] and ERR pulse next cycle, go to IDLE.
  - A MEM_ACK in the same cycle wd_cnt reaches TIMEOUT counts as success (no ERR).
- Latency: grant to MEM_REQ is 1 cycle. The request edge seen in IDLE to MEM_REQ is 2 cycles. MEM_ACK to ACK is 1 cycle.
- Back-to-back: the earliest next MEM_REQ is 2 cycles after ACK (IDLE, ISSUE).
- MEM_* outputs hold their latched values outside ISSUE. Only MEM_REQ is a strobe.
- REQ deasserted mid-transaction: the access still completes and ACK still pulses. Requesters must not change ADDR/WE/WDATA while REQ is high.

Test Plan:
- Single read: REQ[1]=1, ADDR1=0x012345; controller acks 5 cycles after MEM_REQ with 0xBEEF -> MEM_ADDR=0x012345, MEM_WE=0, one MEM_REQ pulse, ACK[1] one cycle later with RDATA=0xBEEF, ERR=0.
- Round-robin: REQ[1] and REQ[2] held continuously with 2-cycle acks -> grant order 1,2,1,2…; GRANT_ID alternates; neither requester waits more than one transaction.
- Hog limit: REQ[0], REQ[1], REQ[2] held, HOG_LIMIT=4 -> grants 0,0,0,0,1,0,0,0,0,2…; hog_cnt clears on each non-zero grant.
- Write path: REQ[2]=1, WE[2]=1, ADDR2=0x7FFFFF, WDATA2=0x55AA -> MEM_WE=1, MEM_ADDR=0x7FFFFF, MEM_WDATA=0x55AA; ACK[2] pulses after MEM_ACK.
- Timeout: controller never acks -> after 256 WAIT cycles ACK[g]=1, ERR=1, RDATA=0xFFFF; the next request is served normally.
- Reset mid-WAIT: assert RESET_n=0 for 1 cycle during WAIT, then MEM_ACK arrives -> no ACK or ERR pulse, BUSY=0, all outputs at reset values; a new REQ[0] is granted normally.
